// File: rtl/fixpu_arb_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// fixpu_arb_pkg - shared types for the FixPU round-robin arbiter
// Rev 1.0
// ------------------------------------------------------------------
package fixpu_arb_pkg;

  localparam int MAX_REQ = 16;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Sized for the largest supported requester count so one tag type fits all.
  localparam int IDX_W = idx_width(MAX_REQ);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i, input int n);
    return (i == IDX_W'(n - 1)) ? '0 : i + IDX_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fixpu_rr_arbiter_rr_pick.sv
`default_nettype none
// ------------------------------------------------------------------
// rr_pick - combinational round-robin priority encoder (one-hot grant)
// Rev 1.0
// ------------------------------------------------------------------
module rr_pick
  import fixpu_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant
);

  logic [2*N_REQ-1:0] rot_wide;
  logic [N_REQ-1:0]   rot;
  logic [N_REQ-1:0]   rot_first;
  logic [2*N_REQ-1:0] back_wide;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    rot_wide  = {valid, valid} >> ptr;
    rot       = rot_wide[N_REQ-1:0];
    rot_first = rot & (~rot + N_REQ'(1));
    back_wide = {rot_first, rot_first} << ptr;
    grant     = back_wide[2*N_REQ-1:N_REQ];
  end

endmodule
`default_nettype wire

// File: rtl/fixpu_rr_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// fixpu_rr_arbiter - shares one pipelined FixPU among N_REQ requesters
// Rev 1.0
// ------------------------------------------------------------------
module fixpu_rr_arbiter
  import fixpu_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int n_int     = 8,
  parameter int n_mant    = 23,
  parameter int LATENCY   = 2,
  parameter int BURST_MAX = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_REQ-1:0]                  req_valid,
  input  logic [N_REQ-1:0]                  req_lock,
  input  logic [N_REQ*(n_int+n_mant)-1:0]   req_a,
  input  logic [N_REQ*(n_int+n_mant)-1:0]   req_b,
  output logic [N_REQ-1:0]                  req_ready,
  output logic [n_int+n_mant-1:0]           pu_a,
  output logic [n_int+n_mant-1:0]           pu_b,
  output logic                              pu_issue,
  input  logic [n_int+n_mant-1:0]           pu_result,
  output logic [N_REQ-1:0]                  rsp_valid,
  output logic [n_int+n_mant-1:0]           rsp_data,
  output logic                              busy
);

  localparam int W     = n_int + n_mant;
  localparam int CNT_W = $clog2(BURST_MAX + 1);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [W-1:0]       pu_a_q, pu_a_d, pu_b_q, pu_b_d;
  tag_t [LATENCY:0]   tag_q, tag_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [W-1:0]       rsp_data_q, rsp_data_d;

  logic [N_REQ-1:0]   rr_grant;
  logic [N_REQ-1:0]   owner_oh;
  logic [N_REQ-1:0]   grant;
  logic               any_grant;
  logic               lock_req;
  logic [IDX_W-1:0]   grant_idx;
  logic [W-1:0]       sel_a, sel_b;
  tag_t               new_tag;
  tag_t               last_tag;
  logic [LATENCY:0]   tag_valid;

  logic [IDX_W-1:0]   idx_chain [0:N_REQ];
  logic [W-1:0]       a_chain   [0:N_REQ];
  logic [W-1:0]       b_chain   [0:N_REQ];

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .valid (req_valid),
    .ptr   (rr_ptr_q),
    .grant (rr_grant)
  );

  assign owner_oh = N_REQ'(1) << owner_q;

  // Nothing is accepted while reset is held, so no op can slip past the flush.
  always_comb begin
    grant = '0;
    if (rst) begin
      if (state_q == LOCK) grant = req_valid & owner_oh;
      else                 grant = rr_grant;
    end
  end

  assign req_ready = grant;
  assign any_grant = |grant;
  assign lock_req  = |(grant & req_lock);

  // One-hot grant to index and operand select as AND-OR chains.
  assign idx_chain[0] = '0;
  assign a_chain[0]   = '0;
  assign b_chain[0]   = '0;
  for (genvar i = 0; i < N_REQ; i++) begin : g_mux
    assign idx_chain[i+1] = idx_chain[i] | (grant[i] ? IDX_W'(i) : '0);
    assign a_chain[i+1]   = a_chain[i]   | (grant[i] ? req_a[i*W +: W] : '0);
    assign b_chain[i+1]   = b_chain[i]   | (grant[i] ? req_b[i*W +: W] : '0);
  end
  assign grant_idx = idx_chain[N_REQ];
  assign sel_a     = a_chain[N_REQ];
  assign sel_b     = b_chain[N_REQ];

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ARB: begin
        if (any_grant) begin
          if (lock_req && (BURST_MAX > 1)) begin
            state_d     = LOCK;
            owner_d     = grant_idx;
            burst_cnt_d = CNT_W'(1);
          end else begin
            rr_ptr_d = wrap_inc(grant_idx, N_REQ);
          end
        end
      end
      LOCK: begin
        if (!any_grant || !lock_req || (burst_cnt_q + CNT_W'(1) == CNT_W'(BURST_MAX))) begin
          state_d     = ARB;
          rr_ptr_d    = wrap_inc(owner_q, N_REQ);
          burst_cnt_d = '0;
        end else begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ARB;
    endcase
  end

  assign last_tag = tag_q[LATENCY];

  // Stage 0 of the tag pipe lines up with pu_issue; the last stage with pu_result.
  always_comb begin
    new_tag.valid = any_grant;
    new_tag.idx   = grant_idx;
    pu_a_d        = any_grant ? sel_a : pu_a_q;
    pu_b_d        = any_grant ? sel_b : pu_b_q;
    tag_d         = {tag_q[LATENCY-1:0], new_tag};
    rsp_valid_d   = last_tag.valid ? (N_REQ'(1) << last_tag.idx) : '0;
    rsp_data_d    = last_tag.valid ? pu_result : rsp_data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      pu_a_q      <= '0;
      pu_b_q      <= '0;
      tag_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      pu_a_q      <= pu_a_d;
      pu_b_q      <= pu_b_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  for (genvar s = 0; s <= LATENCY; s++) begin : g_tag_valid
    assign tag_valid[s] = tag_q[s].valid;
  end

  assign pu_a      = pu_a_q;
  assign pu_b      = pu_b_q;
  assign pu_issue  = tag_q[0].valid;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = |tag_valid;

endmodule
`default_nettype wire

// File: tb/tb_fixpu_rr_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_fixpu_rr_arbiter - scenario and randomized checks of fixpu_rr_arbiter
// Rev 1.0
// ------------------------------------------------------------------
module tb_fixpu_rr_arbiter;

  localparam int N  = 4;
  localparam int NI = 8;
  localparam int NM = 23;
  localparam int W  = NI + NM;
  localparam int L  = 2;
  localparam int BM = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid, req_lock, req_ready, rsp_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0]   pu_a, pu_b, pu_result, rsp_data;
  logic           pu_issue, busy;

  int n_checks = 0;
  int n_fail   = 0;

  fixpu_rr_arbiter #(
    .N_REQ(N), .n_int(NI), .n_mant(NM), .LATENCY(L), .BURST_MAX(BM)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_lock(req_lock),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .pu_a(pu_a), .pu_b(pu_b), .pu_issue(pu_issue), .pu_result(pu_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // FixPU stand-in: an adder with L cycles from inputs to result
  logic [W-1:0] fp_pipe [0:L-1];
  always @(posedge clk) begin
    fp_pipe[0] <= pu_a + pu_b;
    for (int k = 1; k < L; k++) fp_pipe[k] <= fp_pipe[k-1];
  end
  assign pu_result = fp_pipe[L-1];

  // Reference model: arbitration rules on plain ints plus a queue of due responses
  typedef struct { int due; int idx; logic [W-1:0] data; } exp_t;
  exp_t exp_q[$];
  int   cyc     = 0;
  int   m_ptr   = 0;
  int   m_owner = 0;
  int   m_cnt   = 0;
  bit   m_lock  = 0;

  function automatic int model_pick(input logic [N-1:0] v);
    if (m_lock) return v[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ptr = 0; m_owner = 0; m_cnt = 0; m_lock = 0;
      exp_q.delete();
    end else begin
      int g;
      logic [W-1:0] s;
      g = model_pick(req_valid);
      if (g >= 0) begin
        s = req_a[g*W +: W] + req_b[g*W +: W];
        exp_q.push_back('{cyc + L + 2, g, s});
      end
      if (m_lock) begin
        if (g < 0) begin
          m_lock = 0; m_ptr = (m_owner + 1) % N;
        end else begin
          m_cnt++;
          if (!req_lock[g] || m_cnt >= BM) begin m_lock = 0; m_ptr = (g + 1) % N; end
        end
      end else if (g >= 0) begin
        if (req_lock[g] && BM > 1) begin m_lock = 1; m_owner = g; m_cnt = 1; end
        else m_ptr = (g + 1) % N;
      end
      cyc++;
      while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
    end
  end

  task automatic set_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[k*W +: W] = a;
    req_b[k*W +: W] = b;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '0; req_lock = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '1;
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_checks++; if (pu_issue !== 1'b0) begin n_fail++; $display("FAIL reset_issue: got %b want 0", pu_issue); end
    n_checks++; if (pu_a !== '0 || pu_b !== '0) begin n_fail++; $display("FAIL reset_pu_ops: got %h/%h want 0/0", pu_a, pu_b); end
    n_checks++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
    n_checks++; if (rsp_data !== '0) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    req_valid = '0;
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_single();
    logic [W-1:0] a, b, s;
    do_reset();
    a = W'(3) << 23;   // 3.0
    b = W'(3) << 22;   // 1.5
    s = W'(9) << 22;   // 4.5
    set_op(0, a, b);
    req_valid = 4'b0001;
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b want 0001", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      n_checks++; if (pu_issue !== (c == 1)) begin n_fail++; $display("FAIL single_issue c=%0d: got %b", c, pu_issue); end
      n_checks++; if (busy !== (c <= 3)) begin n_fail++; $display("FAIL single_busy c=%0d: got %b", c, busy); end
      n_checks++; if (rsp_valid !== ((c == 4) ? 4'b0001 : 4'b0000)) begin n_fail++; $display("FAIL single_rsp c=%0d: got %b", c, rsp_valid); end
      if (c == 4) begin
        n_checks++; if (rsp_data !== s) begin n_fail++; $display("FAIL single_data: got %h want %h", rsp_data, s); end
      end
    end
  endtask

  task automatic test_fairness();
    logic [W-1:0] sums [N];
    logic [N-1:0] eg, er;
    do_reset();
    for (int k = 0; k < N; k++) begin
      logic [W-1:0] a, b;
      a = W'($urandom); b = W'($urandom);
      set_op(k, a, b);
      sums[k] = a + b;
    end
    req_valid = '1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      eg = (i < 8) ? (N'(1) << (i % 4)) : '0;
      er = (i >= 4) ? (N'(1) << ((i - 4) % 4)) : '0;
      n_checks++; if (req_ready !== eg) begin n_fail++; $display("FAIL fair_grant i=%0d: got %b want %b", i, req_ready, eg); end
      n_checks++; if (rsp_valid !== er) begin n_fail++; $display("FAIL fair_rsp i=%0d: got %b want %b", i, rsp_valid, er); end
      if (i >= 4) begin
        n_checks++; if (rsp_data !== sums[(i - 4) % 4]) begin n_fail++; $display("FAIL fair_data i=%0d: got %h want %h", i, rsp_data, sums[(i - 4) % 4]); end
      end
      @(posedge clk); #1;
      if (i == 7) req_valid = '0;
    end
  endtask

  task automatic test_burst_lock();
    int exp_seq [10] = '{1, 1, 1, 1, 2, 0, 1, 1, 1, 1};
    do_reset();
    for (int k = 0; k < N; k++) set_op(k, W'($urandom), W'($urandom));
    req_valid = 4'b0001;
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL burst_setup: got %b want 0001", req_ready); end
    @(posedge clk); #1;
    req_valid = 4'b0111; req_lock = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++; if (req_ready !== (N'(1) << exp_seq[i])) begin n_fail++; $display("FAIL burst_grant i=%0d: got %b want %0d", i, req_ready, exp_seq[i]); end
      @(posedge clk); #1;
    end
    req_valid = '0; req_lock = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    req_valid = 4'b0100;
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL wrap_first: got %b want 0100", req_ready); end
    @(posedge clk); #1 req_valid = 4'b1001;
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_req3: got %b want 1000", req_ready); end
    @(posedge clk); #1 req_valid = 4'b0001;
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_req0: got %b want 0001", req_ready); end
    @(posedge clk); #1 req_valid = '0;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int k = 0; k < N; k++) set_op(k, W'($urandom), W'($urandom));
    req_valid = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (req_ready !== (N'(1) << i)) begin n_fail++; $display("FAIL mid_grant i=%0d: got %b", i, req_ready); end
      @(posedge clk); #1;
    end
    req_valid = '0;
    @(negedge clk);
    n_checks++; if (pu_issue !== 1'b1) begin n_fail++; $display("FAIL mid_third_issue: got %b want 1", pu_issue); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL mid_in_reset: busy %b rsp %b want 0/0000", busy, rsp_valid); end
    @(posedge clk); #1 rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_after c=%0d: rsp %b busy %b want 0000/0", c, rsp_valid, busy); end
    end
    @(posedge clk); #1 req_valid = 4'b1100;
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL mid_regrant: got %b want 0100", req_ready); end
    @(posedge clk); #1 req_valid = '0;
  endtask

  task automatic test_idle_gaps();
    logic [W-1:0] sums[$];
    logic [W-1:0] a, b, want;
    logic [N-1:0] er;
    int n_rsp = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (i < 12 && (i % 2) == 0) begin
        a = W'($urandom); b = W'($urandom);
        set_op(0, a, b);
        sums.push_back(a + b);
        req_valid = 4'b0001;
      end else begin
        req_valid = 4'b0000;
      end
      @(negedge clk);
      n_checks++; if (req_ready !== req_valid) begin n_fail++; $display("FAIL gap_grant i=%0d: got %b want %b", i, req_ready, req_valid); end
      n_checks++; if (pu_issue !== (i <= 11 && (i % 2) == 1)) begin n_fail++; $display("FAIL gap_issue i=%0d: got %b", i, pu_issue); end
      er = (i >= 4 && i <= 14 && (i % 2) == 0) ? 4'b0001 : 4'b0000;
      n_checks++; if (rsp_valid !== er) begin n_fail++; $display("FAIL gap_rsp i=%0d: got %b want %b", i, rsp_valid, er); end
      if (rsp_valid !== 4'b0000) begin
        n_rsp++;
        want = (sums.size() > 0) ? sums.pop_front() : '0;
        n_checks++; if (rsp_data !== want) begin n_fail++; $display("FAIL gap_data i=%0d: got %h want %h", i, rsp_data, want); end
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    n_checks++; if (n_rsp !== 6) begin n_fail++; $display("FAIL gap_count: got %0d want 6", n_rsp); end
  endtask

  task automatic test_random();
    logic [N-1:0] pend;
    logic [N-1:0] e_ready, e_rv;
    logic [W-1:0] e_rd;
    logic         e_busy, e_issue;
    int           g;
    do_reset();
    pend = '0;
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(99) < 45) begin
          pend[k] = 1'b1;
          set_op(k, W'($urandom), W'($urandom));
        end else if (pend[k] && $urandom_range(99) < 4) begin
          pend[k] = 1'b0;
        end
      end
      req_valid = pend;
      req_lock  = N'($urandom);
      @(negedge clk);
      g       = model_pick(req_valid);
      e_ready = (g >= 0) ? (N'(1) << g) : '0;
      e_rv    = '0;
      e_rd    = '0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e_rv = N'(1) << exp_q[0].idx;
        e_rd = exp_q[0].data;
      end
      e_busy  = (exp_q.size() > 0) && (exp_q[exp_q.size()-1].due > cyc);
      e_issue = (exp_q.size() > 0) && (exp_q[exp_q.size()-1].due == cyc + L + 1);
      n_checks++; if (req_ready !== e_ready) begin n_fail++; $display("FAIL rnd_ready i=%0d: got %b want %b", i, req_ready, e_ready); end
      n_checks++; if (pu_issue !== e_issue) begin n_fail++; $display("FAIL rnd_issue i=%0d: got %b want %b", i, pu_issue, e_issue); end
      n_checks++; if (busy !== e_busy) begin n_fail++; $display("FAIL rnd_busy i=%0d: got %b want %b", i, busy, e_busy); end
      n_checks++; if (rsp_valid !== e_rv) begin n_fail++; $display("FAIL rnd_rsp i=%0d: got %b want %b", i, rsp_valid, e_rv); end
      if (e_rv !== '0) begin
        n_checks++; if (rsp_data !== e_rd) begin n_fail++; $display("FAIL rnd_data i=%0d: got %h want %h", i, rsp_data, e_rd); end
      end
      pend = pend & ~(req_valid & req_ready);
      @(posedge clk); #1;
    end
    req_valid = '0;
    req_lock  = '0;
  endtask

  initial begin
    req_valid = '0;
    req_lock  = '0;
    req_a     = '0;
    req_b     = '0;
    test_reset();
    test_single();
    test_fairness();
    test_burst_lock();
    test_wrap();
    test_reset_midflight();
    test_idle_gaps();
    test_random();
    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
